// File: rtl/iqdemap_bpsk.sv
// BPSK soft-sample demapper: hard-decides each real-axis sample by sign and packs the
// bits LSB-first into 128-bit words for a downstream writer, zero-padding short bursts.
`timescale 1ns/1ps

module iqdemap_bpsk #(
  parameter int W = 11
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ce,
  input  logic                valid_i,
  input  logic signed [W-1:0] xr,
  input  logic signed [W-1:0] xi,
  input  logic                writer_full,
  output logic [127:0]        writer_data,
  output logic                writer_en,
  output logic                valid_raw,
  output logic                raw,
  output logic                overflow,
  output logic                drop
);

  typedef enum logic [1:0] {
    s_idle,
    s_active,
    s_flush
  } state_t;

  state_t       state_q, state_d;
  logic [6:0]   cnt_q;
  logic [127:0] sr_q, sr_d;
  logic         wen_r;

  logic         bit_dec;
  logic         shift_en;
  logic         shift_bit;
  logic         emit;
  logic         drop_set;

  // BPSK carries nothing on the imaginary axis and only the sign of xr matters.
  logic         unused_inputs;
  assign unused_inputs = ^{xi, xr[W-2:0]};

  // Sign decision: zero counts as non-negative and decides 1.
  assign bit_dec = ~xr[W-1];

  assign sr_d = {shift_bit, sr_q[127:1]};

  // NOTE: every signal driven here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    shift_bit = 1'b0;
    emit      = 1'b0;
    drop_set  = 1'b0;
    unique case (state_q)
      s_idle: begin
        if (valid_i) begin
          shift_en  = 1'b1;
          shift_bit = bit_dec;
          state_d   = s_active;
        end
      end
      s_active: begin
        if (valid_i) begin
          shift_en  = 1'b1;
          shift_bit = bit_dec;
          if (cnt_q == 7'd127) begin
            emit    = 1'b1;
            state_d = s_idle;
          end
        end else begin
          state_d = s_flush;
        end
      end
      s_flush: begin
        // Pad with zeros until the word is full; anything arriving now is lost.
        shift_en  = 1'b1;
        shift_bit = 1'b0;
        drop_set  = valid_i;
        if (cnt_q == 7'd127) begin
          emit    = 1'b1;
          state_d = s_idle;
        end
      end
      default: state_d = s_idle;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  // NOTE: the 128-bit shift register is a plain register, not a memory, so it is
  // cleared by reset; a reset mid-word must leave no stale bits behind.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= s_idle;
      cnt_q       <= '0;
      sr_q        <= '0;
      writer_data <= '0;
      wen_r       <= 1'b0;
      valid_raw   <= 1'b0;
      raw         <= 1'b0;
      overflow    <= 1'b0;
      drop        <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      raw       <= bit_dec;
      valid_raw <= valid_i;
      if (shift_en) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_q + 7'd1;
      end
      wen_r <= emit & ~writer_full;
      if (emit) begin
        writer_data <= sr_d;
      end
      if (emit && writer_full) begin
        overflow <= 1'b1;
      end
      if (drop_set) begin
        drop <= 1'b1;
      end
    end
  end

  assign writer_en = wen_r & ce;

endmodule

// File: tb/tb_iqdemap_bpsk.sv
// Scoreboard bench for iqdemap_bpsk: expected words are queued as samples are driven
// and popped when writer_en pulses.
`timescale 1ns/1ps

module tb_iqdemap_bpsk;

  localparam int W = 11;
  localparam logic signed [W-1:0] P8 = W'(8);
  localparam logic signed [W-1:0] N8 = W'(-8);

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                ce = 1'b0;
  logic                valid_i = 1'b0;
  logic                writer_full = 1'b0;
  logic signed [W-1:0] xr = '0;
  logic signed [W-1:0] xi = '0;
  logic [127:0]        writer_data;
  logic                writer_en;
  logic                valid_raw;
  logic                raw;
  logic                overflow;
  logic                drop;

  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [127:0] sb[$];
  int           pulses[$];
  logic [127:0] last_word = '0;
  int           last_cap = 0;

  iqdemap_bpsk #(.W(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ce          (ce),
    .valid_i     (valid_i),
    .xr          (xr),
    .xi          (xi),
    .writer_full (writer_full),
    .writer_data (writer_data),
    .writer_en   (writer_en),
    .valid_raw   (valid_raw),
    .raw         (raw),
    .overflow    (overflow),
    .drop        (drop)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (!ce) check("wen_while_ce0", {127'd0, writer_en}, 128'd0);
    if (writer_en) begin
      pulses.push_back(cyc);
      if (sb.size() == 0) check("sb_depth_at_wen", 128'(sb.size()), 128'd1);
      else check("word", writer_data, sb.pop_front());
    end
  end

  // One clock: drive inputs, wait for the edge, check the raw tap.
  task automatic step(input logic v, input logic signed [W-1:0] x, input logic c);
    logic prev_raw, prev_vr, exp_bit;
    prev_raw = raw;
    prev_vr  = valid_raw;
    exp_bit  = ~x[W-1];
    valid_i  = v;
    xr       = x;
    xi       = W'($urandom());
    ce       = c;
    @(posedge CLK);
    #1;
    if (c) begin
      check("raw", {127'd0, raw}, {127'd0, exp_bit});
      check("valid_raw", {127'd0, valid_raw}, {127'd0, v});
    end else begin
      check("raw_hold", {127'd0, raw}, {127'd0, prev_raw});
      check("valid_raw_hold", {127'd0, valid_raw}, {127'd0, prev_vr});
    end
  endtask

  // kind: 0 alternating +8/-8, 1 constant cval, 2 random +/-8.
  task automatic run_burst(input int n, input int kind, input logic signed [W-1:0] cval,
                           input bit push, input bit alt_ce);
    logic [127:0]        word;
    logic signed [W-1:0] x;
    word = '0;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       x = (i % 2 == 0) ? P8 : N8;
        1:       x = cval;
        default: x = ($urandom_range(0, 1) == 1) ? P8 : N8;
      endcase
      word[i % 128] = ~x[W-1];
      if (i % 128 == 127) begin
        if (push) sb.push_back(word);
        last_word = word;
        word = '0;
      end
      step(1'b1, x, 1'b1);
      last_cap = cyc;
      if (alt_ce) step(1'($urandom_range(0, 1)), W'($urandom()), 1'b0);
    end
    if (n % 128 != 0) begin
      if (push) sb.push_back(word);
      last_word = word;
    end
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while (sb.size() != 0 && k < max_cycles) begin
      step(1'b0, '0, 1'b1);
      k++;
    end
    check("drain_left", 128'(sb.size()), 128'd0);
    repeat (3) step(1'b0, '0, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int cap;

    // Reset state
    #12;
    check("rst_writer_data", writer_data, 128'd0);
    check("rst_writer_en", {127'd0, writer_en}, 128'd0);
    check("rst_raw", {127'd0, raw}, 128'd0);
    check("rst_valid_raw", {127'd0, valid_raw}, 128'd0);
    check("rst_overflow", {127'd0, overflow}, 128'd0);
    check("rst_drop", {127'd0, drop}, 128'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;

    // Alternating pattern, full rate
    p0 = pulses.size();
    run_burst(128, 0, '0, 1'b1, 1'b0);
    drain(10);
    check("alt_pulses", 128'(pulses.size()), 128'(p0 + 1));
    if (pulses.size() > p0) check("alt_latency", 128'(pulses[p0]), 128'(last_cap));
    check("alt_word_hold", writer_data, {64{2'b01}});

    // Zero threshold and negative extremes
    run_burst(128, 1, W'(0), 1'b1, 1'b0);
    drain(10);
    check("zero_word", writer_data, {128{1'b1}});
    run_burst(128, 1, W'(-1), 1'b1, 1'b0);
    drain(10);
    check("neg1_word", writer_data, 128'd0);
    run_burst(128, 1, W'(-1024), 1'b1, 1'b0);
    drain(10);
    check("negmax_word", writer_data, 128'd0);

    // Streaming: 3 contiguous words
    p0 = pulses.size();
    run_burst(384, 2, '0, 1'b1, 1'b0);
    drain(10);
    check("stream_pulses", 128'(pulses.size()), 128'(p0 + 3));
    for (int k = 1; k < 3; k++) begin
      if (pulses.size() > p0 + k)
        check("stream_spacing", 128'(pulses[p0 + k] - pulses[p0 + k - 1]), 128'd128);
    end

    // Partial burst with a sample injected during the flush
    check("drop_before", {127'd0, drop}, 128'd0);
    p0 = pulses.size();
    run_burst(5, 1, P8, 1'b1, 1'b0);
    cap = last_cap;
    repeat (40) step(1'b0, '0, 1'b1);
    step(1'b1, P8, 1'b1);
    check("drop_set", {127'd0, drop}, 128'd1);
    drain(200);
    check("partial_pulses", 128'(pulses.size()), 128'(p0 + 1));
    if (pulses.size() > p0) check("flush_length", 128'(pulses[p0]), 128'(cap + 124));
    check("partial_word", writer_data, 128'h1F);
    check("drop_sticky", {127'd0, drop}, 128'd1);

    // ce throttling
    p0 = pulses.size();
    run_burst(128, 0, '0, 1'b1, 1'b1);
    drain(10);
    check("ce_pulses", 128'(pulses.size()), 128'(p0 + 1));
    check("ce_word", writer_data, {64{2'b01}});

    // Backpressure: word lost, overflow sticky
    check("ovf_before", {127'd0, overflow}, 128'd0);
    writer_full = 1'b1;
    p0 = pulses.size();
    run_burst(128, 2, '0, 1'b0, 1'b0);
    repeat (2) step(1'b0, '0, 1'b1);
    writer_full = 1'b0;
    repeat (10) step(1'b0, '0, 1'b1);
    check("ovf_no_pulse", 128'(pulses.size()), 128'(p0));
    check("ovf_set", {127'd0, overflow}, 128'd1);
    check("ovf_data", writer_data, last_word);

    // Async reset mid-word
    run_burst(60, 2, '0, 1'b0, 1'b0);
    #3;
    RST = 1'b0;
    #1;
    check("arst_writer_data", writer_data, 128'd0);
    check("arst_raw", {127'd0, raw}, 128'd0);
    check("arst_valid_raw", {127'd0, valid_raw}, 128'd0);
    check("arst_overflow", {127'd0, overflow}, 128'd0);
    check("arst_drop", {127'd0, drop}, 128'd0);
    check("arst_writer_en", {127'd0, writer_en}, 128'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    p0 = pulses.size();
    run_burst(128, 2, '0, 1'b1, 1'b0);
    drain(10);
    check("post_rst_pulses", 128'(pulses.size()), 128'(p0 + 1));
    check("post_rst_word", writer_data, last_word);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iqdemap_bpsk.md
Name: iqdemap_bpsk

Overview:
- Receive-side inverse of the BPSK IQ mapper.
- Takes one real-axis soft sample per enabled cycle and decides a bit from its sign.
- Packs bits LSB-first into 128-bit words and pushes each complete word into a downstream writer (FIFO/DRAM writer).
- A burst that ends mid-word is zero-padded to 128 bits and flushed, so the writer only ever sees whole words.

Parameters:
- W, 11, sample width of xr/xi (two's complement).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; no state, output register or counter changes when ce=0.
- valid_i  in  1  xr/xi carry a valid symbol this cycle.
- xr  in  W  real part, signed.
- xi  in  W  imaginary part; ignored by BPSK.
- writer_full  in  1  downstream cannot accept a word.
- writer_data  out  128  packed word; bit 0 = first received symbol.
- writer_en  out  1  word push strobe.
- valid_raw  out  1  registered copy of valid_i.
- raw  out  1  registered decided bit.
- overflow  out  1  sticky: a word was dropped because writer_full=1.
- drop  out  1  sticky: samples arrived during flush and were discarded.

Behaviour:
- Reset (RST=0, async): state=s_idle, counter=0, shift register=0, writer_data=0, wen_r=0, valid_raw=0, raw=0, overflow=0, drop=0.
- Reset mid-word discards the partial word; no emission.
- Decision: bit = ~xr[W-1], so xr>=0 gives 1 (including 0) and xr<0 gives 0. Magnitude is ignored.
- Raw tap: on each ce cycle, raw <= bit and valid_raw <= valid_i. Latency is 1 ce-cycle.
- Shift: on each ce cycle in which a bit is accepted, sr <= {bit, sr[127:1]} and counter (7 bit) increments with natural wrap 127→0.
- State machine, all transitions gated by ce:
  - s_idle: counter=0. On valid_i, accept bit and go to s_active.
  - s_active:
    - valid_i and counter==127: accept bit, emit word, go to s_idle (counter wraps to 0).
    - valid_i and counter<127: accept bit, stay.
    - !valid_i: go to s_flush; this cycle shifts nothing.
  - s_flush:
    - Each ce cycle shifts in bit 0 and increments counter.
    - At counter==127 the shift completes, the word is emitted, and the state goes to s_idle.
    - valid_i=1 in s_flush: the sample is discarded and drop <= 1.
- Back-to-back words: valid_i held continuously gives s_active→s_idle→s_active with no bubble. The s_idle cycle accepts valid_i like any other cycle.
- Emit:
  - writer_data <= final shifted value, including the bit shifted in that same cycle.
  - If writer_full=0: wen_r <= 1. Otherwise wen_r stays 0, overflow <= 1, and the word is lost.
- writer_en = wen_r & ce.
- wen_r clears on the next ce cycle unless a new emit occurs. Emits are at least 128 ce-cycles apart, so writer_en is a single ce-qualified pulse one ce-cycle after the final bit.
- writer_data holds its value until the next emit.
- overflow and drop clear only on reset.

Test Plan:
- Alternating pattern: 128 samples +8,-8,+8,… with ce=1 → single writer_en pulse one cycle after the 128th sample; writer_data=128'h5555…5555; raw/valid_raw follow the input delayed by 1 cycle.
- Zero threshold: 128 samples xr=0 → writer_data all ones. 128 samples xr=-1 → all zeros. 128 samples xr=-1024 → all zeros.
- Streaming: 384 contiguous valid samples → exactly 3 writer_en pulses, 128 cycles apart, with no missing or duplicated bits. Check against a scoreboard of random ±8 input.
- Partial burst: 5 samples of +8 then valid_i=0 → s_flush lasts 123 cycles; writer_data=128'h1F; one writer_en. A sample with valid_i=1 injected during the flush → drop=1 and the word is unchanged.
- ce throttling: the first scenario repeated with ce toggling 1,0,1,0 → identical writer_data; no state or output change on ce=0 cycles; writer_en never high while ce=0.
- Backpressure and reset:
  - writer_full=1 at an emit → no writer_en, overflow=1 and held.
  - Async RST pulse after 60 samples → all outputs return to 0 immediately.
  - A following 128-sample burst emits a clean word containing no bits from before the reset.
